mul_sequencer: RTL
==================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 start  in  1  request a multiply; sampled only in IDLE.
REQ-004 signed_mul  in  1  1 = SMUL (two's complement), 0 = UMUL; sampled with start.
REQ-005 op_a, op_b  in  32 each  multiplicand, multiplier; sampled with start.
REQ-006 busy  out  1  high from the cycle after start acceptance through DONE inclusive.
REQ-007 done  out  1  one-cycle pulse; result valid.
REQ-008 prod_hi, prod_lo  out  32 each  64-bit product; prod_hi is the Y-register value.
REQ-009 icc_n, icc_z, icc_v, icc_c  out  1 each  condition codes for UMULcc/SMULcc.
REQ-010 alu_op  out  6; alu_a, alu_b  out  32 each; alu_cin  out  1  drive the shared external combinational ALU.
REQ-011 alu_res  in  32; alu_c  in  1  ALU result and carry/borrow flag, sampled at the clock edge.

Function
REQ-012 FSM states: IDLE, ABS_A, ABS_B, STEP, NEG_LO, NEG_HI, DONE.
REQ-013 IDLE -> ABS_A when start=1; operands and signed_mul are registered on that edge.
REQ-014 ABS_A: if signed and op_a[31]=1, the ALU computes 0 - a with SUBcc (6'b010100) and the result replaces a; otherwise a holds; then -> ABS_B.
REQ-015 ABS_B: same as ABS_A, applied to b; then -> STEP with the 6-bit step counter = 0.
REQ-016 STEP, with acc = 32-bit high accumulator (cleared at start) and mq = multiplier register: drive ADDcc (6'b010000), alu_a = acc, alu_b = mq[0] ? a : 0; on the edge, {acc, mq} <= {alu_c, alu_res, mq[31:1]}.
REQ-017 STEP repeats exactly 32 times; after the 32nd step -> NEG_LO.
REQ-018 NEG_LO: if signed and the original sign bits differ, mq <= result of 0 - mq via SUBcc, and the borrow alu_c is latched; otherwise no change. Then -> NEG_HI.
REQ-019 NEG_HI: when negating, acc <= result of 0 - acc - borrow via SUBXcc (6'b011100, alu_cin = latched borrow). Then -> DONE.
REQ-020 DONE: prod_hi <= acc and prod_lo <= mq are loaded; done = 1 for one cycle; -> IDLE.
REQ-021 Latency is fixed: done is high exactly 37 cycles after the start-sampling edge, for every operand and both modes.
REQ-022 start while busy is ignored; it is not queued.
REQ-023 prod_hi/prod_lo hold their values until the next DONE.
REQ-024 In IDLE, and in skipped ABS/NEG cycles, alu_op = 6'b000000 and alu_a = alu_b = alu_cin = 0. The ALU inputs are never X.
REQ-025 op_a = 32'h80000000 (signed): the magnitude 2^31 is represented correctly as unsigned; no special case.

Reset
REQ-026 rst_n low forces IDLE at any time, including mid-STEP; busy = done = 0, prod_hi = prod_lo = 0, icc_* = 0, alu_* = 0, and the internal registers are cleared.
REQ-027 After rst_n deasserts, the first start is accepted normally.

Configuration
REQ-028 Macro MUL_SEQ_ICC_EN defined: at DONE, icc_n = prod_lo[31], icc_z = (prod_lo == 0), icc_v = 0, icc_c = 0; these values hold until the next DONE.
REQ-029 Macro MUL_SEQ_ICC_EN undefined: the icc_* ports remain and are tied to 0; no flag logic is built.

Structure
REQ-030 Package mul_seq_pkg holds:
- the state encoding;
- ALU opcode constants ALU_ADDCC = 6'b010000, ALU_SUBCC = 6'b010100, ALU_SUBXCC = 6'b011100;
- MUL_STEPS = 32.
REQ-031 No sub-module is instantiated. The ALU is external, instantiated by the integrating datapath, and muxed onto alu_* while busy.

Verification
REQ-032 Unsigned 3 x 5 -> prod_hi = 0, prod_lo = 15; done exactly 37 cycles after start; busy is high for cycles 1-37.
REQ-033 Unsigned FFFFFFFF x FFFFFFFF -> prod_hi = FFFFFFFE, prod_lo = 00000001.
REQ-034 Signed FFFFFFFD x 5 (-3 x 5) -> prod_hi = FFFFFFFF, prod_lo = FFFFFFF1; signed 80000000 x 80000000 -> prod_hi = 40000000, prod_lo = 0.
REQ-035 rst_n pulsed low at STEP 10 -> busy = 0, done = 0, prod = 0 the same cycle; a new 7 x 6 then yields 42.
REQ-036 start reasserted on cycle 5 while busy -> ignored; exactly one done pulse is produced, carrying the first result.
REQ-037 With MUL_SEQ_ICC_EN, 0 x 1234 -> icc_z = 1, icc_n = 0; signed -1 x 1 -> icc_n = 1, icc_z = 0. Without the macro, all icc_* = 0.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the 32x32 shift-add multiply sequencer.
// Holds the FSM state encoding, the opcodes the sequencer drives onto the
// shared external ALU, the step count and the ALU request payload struct.
package mul_seq_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned OP_W      = 6;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned MUL_STEPS = 32;

  localparam logic [OP_W-1:0] ALU_NOP    = 6'b000000;
  localparam logic [OP_W-1:0] ALU_ADDCC  = 6'b010000;
  localparam logic [OP_W-1:0] ALU_SUBCC  = 6'b010100;
  localparam logic [OP_W-1:0] ALU_SUBXCC = 6'b011100;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABS_A  = 3'd1,
    ABS_B  = 3'd2,
    STEP   = 3'd3,
    NEG_LO = 3'd4,
    NEG_HI = 3'd5,
    DONE   = 3'd6
  } state_t;

  // One request to the external combinational ALU.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
  } alu_req_t;

endpackage

// File: rtl/mul_sequencer.sv
// mul_sequencer: UMUL/SMUL sequencer that borrows a shared external ALU.
// Signed operands are made positive (ABS_A/ABS_B), multiplied by 32
// shift-add steps, and the 64-bit product is negated (NEG_LO/NEG_HI) when the
// original signs differ. Latency from the start-sampling edge to done is 37.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, signed_mul          request (sampled in IDLE only), SMUL select
//   op_a, op_b                 multiplicand, multiplier
//   busy, done                 in-flight flag, one-cycle result pulse
//   prod_hi, prod_lo           64-bit product (prod_hi = Y register)
//   icc_n/z/v/c                condition codes
//   alu_op/a/b/cin             request driven to the external ALU
//   alu_res, alu_c             ALU result and carry/borrow
//
// Config: MUL_SEQ_ICC_EN builds the icc_n/icc_z flag registers; without it
// all icc_* outputs are tied to 0.
module mul_sequencer
  import mul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              signed_mul,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] prod_hi,
  output logic [DATA_W-1:0] prod_lo,
  output logic              icc_n,
  output logic              icc_z,
  output logic              icc_v,
  output logic              icc_c,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_c
);

  state_t            state, state_nx;
  logic [DATA_W-1:0] a_q, a_nx;
  logic [DATA_W-1:0] mq_q, mq_nx;
  logic [DATA_W-1:0] acc_q, acc_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic              sgn_q, sgn_nx;
  logic              neg_q, neg_nx;
  logic              borrow_q, borrow_nx;
  logic              busy_nx, done_nx;
  logic [DATA_W-1:0] prod_hi_nx, prod_lo_nx;
  alu_req_t          alu_q, alu_nx;

  // State register and all datapath/output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      mq_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      borrow_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      prod_hi  <= '0;
      prod_lo  <= '0;
      alu_q    <= '0;
    end else begin
      state    <= state_nx;
      a_q      <= a_nx;
      mq_q     <= mq_nx;
      acc_q    <= acc_nx;
      cnt_q    <= cnt_nx;
      sgn_q    <= sgn_nx;
      neg_q    <= neg_nx;
      borrow_q <= borrow_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      prod_hi  <= prod_hi_nx;
      prod_lo  <= prod_lo_nx;
      alu_q    <= alu_nx;
    end
  end

  // Next-state and datapath updates; the ALU request for the coming cycle is
  // derived from the next-cycle values so alu_* are registered yet aligned.
  always_comb begin
    state_nx   = state;
    a_nx       = a_q;
    mq_nx      = mq_q;
    acc_nx     = acc_q;
    cnt_nx     = cnt_q;
    sgn_nx     = sgn_q;
    neg_nx     = neg_q;
    borrow_nx  = borrow_q;
    prod_hi_nx = prod_hi;
    prod_lo_nx = prod_lo;
    alu_nx     = '0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx  = ABS_A;
          a_nx      = op_a;
          mq_nx     = op_b;
          acc_nx    = '0;
          cnt_nx    = '0;
          sgn_nx    = signed_mul;
          neg_nx    = signed_mul & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
          borrow_nx = 1'b0;
        end
      end
      ABS_A: begin
        if (sgn_q && a_q[DATA_W-1]) a_nx = alu_res;
        state_nx = ABS_B;
      end
      ABS_B: begin
        if (sgn_q && mq_q[DATA_W-1]) mq_nx = alu_res;
        cnt_nx   = '0;
        state_nx = STEP;
      end
      STEP: begin
        // Carry-out becomes the top accumulator bit; low sum bit shifts into mq.
        acc_nx = {alu_c, alu_res[DATA_W-1:1]};
        mq_nx  = {alu_res[0], mq_q[DATA_W-1:1]};
        cnt_nx = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_STEPS - 1)) state_nx = NEG_LO;
      end
      NEG_LO: begin
        if (neg_q) begin
          mq_nx     = alu_res;
          borrow_nx = alu_c;
        end
        state_nx = NEG_HI;
      end
      NEG_HI: begin
        if (neg_q) acc_nx = alu_res;
        // Product registers load here so they are valid while done is high.
        prod_hi_nx = acc_nx;
        prod_lo_nx = mq_q;
        state_nx   = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == DONE);

    unique case (state_nx)
      ABS_A: begin
        if (sgn_nx && a_nx[DATA_W-1]) begin
          alu_nx.op = ALU_SUBCC;
          alu_nx.b  = a_nx;
        end
      end
      ABS_B: begin
        if (sgn_nx && mq_nx[DATA_W-1]) begin
          alu_nx.op = ALU_SUBCC;
          alu_nx.b  = mq_nx;
        end
      end
      STEP: begin
        alu_nx.op = ALU_ADDCC;
        alu_nx.a  = acc_nx;
        alu_nx.b  = mq_nx[0] ? a_nx : '0;
      end
      NEG_LO: begin
        if (neg_nx) begin
          alu_nx.op = ALU_SUBCC;
          alu_nx.b  = mq_nx;
        end
      end
      NEG_HI: begin
        if (neg_nx) begin
          alu_nx.op  = ALU_SUBXCC;
          alu_nx.b   = acc_nx;
          alu_nx.cin = borrow_nx;
        end
      end
      default: begin
        alu_nx = '0;
      end
    endcase
  end

  assign alu_op  = alu_q.op;
  assign alu_a   = alu_q.a;
  assign alu_b   = alu_q.b;
  assign alu_cin = alu_q.cin;

`ifdef MUL_SEQ_ICC_EN
  // N/Z flags track the low product word, captured alongside prod_lo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icc_n <= 1'b0;
      icc_z <= 1'b0;
    end else if (done_nx) begin
      icc_n <= prod_lo_nx[DATA_W-1];
      icc_z <= (prod_lo_nx == '0);
    end
  end
  assign icc_v = 1'b0;
  assign icc_c = 1'b0;
`else
  assign icc_n = 1'b0;
  assign icc_z = 1'b0;
  assign icc_v = 1'b0;
  assign icc_c = 1'b0;
`endif

endmodule
